// File: rtl/operand_stage_if.sv
// Port bundle between the issue controller and operand_stage: issue request,
// write-back from the ALU result path, and the registered ALU operands.
interface operand_stage_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
);
  logic             issue_valid;
  logic             stall;
  logic [AW-1:0]    rs_addr;
  logic [AW-1:0]    rt_addr;
  logic [WIDTH-1:0] imm;
  logic             use_imm;
  logic             alu_ctrl_in;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             alu_ctrl;
  logic             op_valid;

  modport master (
    output issue_valid, stall, rs_addr, rt_addr, imm, use_imm, alu_ctrl_in,
    output wb_en, wb_addr, wb_data,
    input  input1, input2, alu_ctrl, op_valid
  );

  modport slave (
    input  issue_valid, stall, rs_addr, rt_addr, imm, use_imm, alu_ctrl_in,
    input  wb_en, wb_addr, wb_data,
    output input1, input2, alu_ctrl, op_valid
  );
endinterface

// File: rtl/operand_stage.sv
// Register file plus registered ALU operand stage with write-back bypass and immediate select.
// Issue to valid operands is one cycle; stall freezes the operand register, write-back never stalls.
module operand_stage #(
  parameter int WIDTH = 8,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic           clk,
  input  logic           n_reset,
  operand_stage_if.slave bus
);

  localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic [WIDTH-1:0] input1_q, input1_d;
  logic [WIDTH-1:0] input2_q, input2_d;
  logic             alu_ctrl_q, alu_ctrl_d;
  logic             op_valid_q, op_valid_d;

  logic             wb_ok;
  logic             rs_ok;
  logic             rt_ok;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  // r0 and addresses beyond the implemented file are neither writable nor readable
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_L);
  endfunction

  always_comb begin
    wb_ok  = bus.wb_en && addr_ok(bus.wb_addr);
    rs_ok  = addr_ok(bus.rs_addr);
    rt_ok  = addr_ok(bus.rt_addr);
    rs_val = '0;
    rt_val = '0;
    if (rs_ok) begin
      rs_val = (wb_ok && (bus.wb_addr == bus.rs_addr)) ? bus.wb_data : regs_q[bus.rs_addr];
    end
    if (rt_ok) begin
      rt_val = (wb_ok && (bus.wb_addr == bus.rt_addr)) ? bus.wb_data : regs_q[bus.rt_addr];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_ok) begin
      regs_d[bus.wb_addr] = bus.wb_data;
    end
  end

  always_comb begin
    input1_d   = input1_q;
    input2_d   = input2_q;
    alu_ctrl_d = alu_ctrl_q;
    op_valid_d = op_valid_q;
    if (!bus.stall) begin
      op_valid_d = bus.issue_valid;
      if (bus.issue_valid) begin
        input1_d   = rs_val;
        input2_d   = bus.use_imm ? bus.imm : rt_val;
        alu_ctrl_d = bus.alu_ctrl_in;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      regs_q     <= '{default: '0};
      input1_q   <= '0;
      input2_q   <= '0;
      alu_ctrl_q <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      input1_q   <= input1_d;
      input2_q   <= input2_d;
      alu_ctrl_q <= alu_ctrl_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign bus.input1   = input1_q;
  assign bus.input2   = input2_q;
  assign bus.alu_ctrl = alu_ctrl_q;
  assign bus.op_valid = op_valid_q;

endmodule
